// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin arbiter sharing one ALU between two requesters;
//             one operation in flight, result returned to its owner port.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_b1,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  input  logic              rsp_ready0,
  input  logic              rsp_ready1,
  output logic [WIDTH-1:0]  rsp_y,
  output logic              rsp_cout,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_y,
  input  logic              alu_cout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  logic   r_prio;
  logic   r_owner;
  logic   w_idle;
  logic   w_rsp_done;

  assign w_idle = (r_state == IDLE);

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  assign req_ready0 = rst_n && w_idle && req_valid0 && (!req_valid1 || !r_prio);
  assign req_ready1 = rst_n && w_idle && req_valid1 && (!req_valid0 ||  r_prio);

  assign w_rsp_done = r_owner ? rsp_ready1 : rsp_ready0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_y      <= '0;
      rsp_cout   <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_ready0) begin
            alu_a    <= req_a0;
            alu_b    <= req_b0;
            alu_ctrl <= req_ctrl0;
            r_owner  <= 1'b0;
            r_prio   <= 1'b1;
            r_state  <= EXEC;
            busy     <= 1'b1;
          end else if (req_ready1) begin
            alu_a    <= req_a1;
            alu_b    <= req_b1;
            alu_ctrl <= req_ctrl1;
            r_owner  <= 1'b1;
            r_prio   <= 1'b0;
            r_state  <= EXEC;
            busy     <= 1'b1;
          end
        end
        EXEC: begin
          rsp_y      <= alu_y;
          rsp_cout   <= alu_cout;
          rsp_valid0 <= !r_owner;
          rsp_valid1 <=  r_owner;
          r_state    <= RESP;
        end
        RESP: begin
          if (w_rsp_done) begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter against a transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid0, req_valid1;
  logic              req_ready0, req_ready1;
  logic [WIDTH-1:0]  req_a0, req_a1, req_b0, req_b1;
  logic [CTRL_W-1:0] req_ctrl0, req_ctrl1;
  logic              rsp_valid0, rsp_valid1;
  logic              rsp_ready0, rsp_ready1;
  logic [WIDTH-1:0]  rsp_y;
  logic              rsp_cout;
  logic [WIDTH-1:0]  alu_a, alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_y;
  logic              alu_cout;
  logic              busy;

  always #5 clk = ~clk;

  // Stand-in ALU: adds for every opcode.
  assign {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_y(rsp_y), .rsp_cout(rsp_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_cout(alu_cout), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: at most one operation, which spends one cycle
  // executing and then waits for its owner to take the result.
  bit              m_have_op;
  int              m_owner;
  int              m_age;
  int              m_prio;
  logic [WIDTH-1:0]  m_alu_a, m_alu_b, m_y;
  logic [CTRL_W-1:0] m_alu_ctrl;
  logic              m_cout;

  int cyc = 0;
  bit rec_en = 0;
  int grant_port[$];
  int grant_cyc[$];
  bit g0, g1;

  function automatic int winner();
    if (!rst_n || m_have_op) return -1;
    if (req_valid0 && req_valid1) return m_prio;
    if (req_valid0) return 0;
    if (req_valid1) return 1;
    return -1;
  endfunction

  task automatic check_model();
    int w;
    w = winner();
    chk("busy",       busy,       m_have_op);
    chk("req_ready0", req_ready0, w == 0);
    chk("req_ready1", req_ready1, w == 1);
    chk("rsp_valid0", rsp_valid0, m_have_op && m_age >= 1 && m_owner == 0);
    chk("rsp_valid1", rsp_valid1, m_have_op && m_age >= 1 && m_owner == 1);
    chk("alu_a",      alu_a,      m_alu_a);
    chk("alu_b",      alu_b,      m_alu_b);
    chk("alu_ctrl",   alu_ctrl,   m_alu_ctrl);
    chk("rsp_y",      rsp_y,      m_y);
    chk("rsp_cout",   rsp_cout,   m_cout);
    g0 = (req_ready0 === 1'b1);
    g1 = (req_ready1 === 1'b1);
    if (rec_en && g0) begin grant_port.push_back(0); grant_cyc.push_back(cyc); end
    if (rec_en && g1) begin grant_port.push_back(1); grant_cyc.push_back(cyc); end
  endtask

  task automatic model_update();
    int w;
    w = winner();
    if (!rst_n) begin
      m_have_op = 0; m_prio = 0; m_age = 0; m_owner = 0;
      m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0; m_y = '0; m_cout = 1'b0;
    end else if (m_have_op) begin
      if (m_age == 0) begin
        {m_cout, m_y} = {1'b0, m_alu_a} + {1'b0, m_alu_b};
        m_age = 1;
      end else if ((m_owner == 0) ? rsp_ready0 : rsp_ready1) begin
        m_have_op = 0;
      end
    end else if (w >= 0) begin
      m_have_op  = 1;
      m_age      = 0;
      m_owner    = w;
      m_prio     = 1 - w;
      m_alu_a    = (w == 0) ? req_a0 : req_a1;
      m_alu_b    = (w == 0) ? req_b0 : req_b1;
      m_alu_ctrl = (w == 0) ? req_ctrl0 : req_ctrl1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    req_valid0 = 0; req_valid1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] held_y;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};

    // 1. Reset with both requesters asserting.
    rst_n = 0; req_valid0 = 1; req_valid1 = 1; rsp_ready0 = 0; rsp_ready1 = 0;
    req_a0 = 32'd1; req_b0 = 32'd2; req_ctrl0 = 3'd1;
    req_a1 = 32'd3; req_b1 = 32'd4; req_ctrl1 = 3'd2;
    @(posedge clk); model_update(); #1;
    tick();
    chk("rst_ready0", req_ready0, 0);
    chk("rst_ready1", req_ready1, 0);
    chk("rst_rspv0",  rsp_valid0, 0);
    chk("rst_rspv1",  rsp_valid1, 0);
    chk("rst_alu_a",  alu_a, 0);
    chk("rst_alu_b",  alu_b, 0);
    chk("rst_ctrl",   alu_ctrl, 0);
    chk("rst_busy",   busy, 0);

    // 2. Single op on port 0.
    rst_n = 1; idle_inputs();
    req_valid0 = 1; req_a0 = 32'd16; req_b0 = 32'd3; req_ctrl0 = 3'b010;
    #1;
    chk("t2_ready0", req_ready0, 1);
    tick();
    req_valid0 = 0;
    chk("t2_alu_a", alu_a, 16);
    chk("t2_alu_b", alu_b, 3);
    chk("t2_ctrl",  alu_ctrl, 3'b010);
    tick();
    chk("t2_rspv0", rsp_valid0, 1);
    chk("t2_rspv1", rsp_valid1, 0);
    chk("t2_y",     rsp_y, 19);
    chk("t2_cout",  rsp_cout, 0);
    rsp_ready0 = 1;
    tick();
    rsp_ready0 = 0;
    chk("t2_idle", busy, 0);

    // 5. Carry on port 1.
    req_valid1 = 1; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_ctrl1 = 3'b111;
    tick();
    req_valid1 = 0;
    tick();
    chk("t5_rspv1", rsp_valid1, 1);
    chk("t5_y",     rsp_y, 0);
    chk("t5_cout",  rsp_cout, 1);
    rsp_ready1 = 1;
    tick();
    rsp_ready1 = 0;

    // 3. Contention from reset with responses always consumed.
    rst_n = 0; tick();
    rst_n = 1; req_valid0 = 1; req_valid1 = 1; rsp_ready0 = 1; rsp_ready1 = 1;
    grant_port.delete(); grant_cyc.delete();
    rec_en = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (g0) begin req_a0 = $urandom; req_b0 = $urandom; req_ctrl0 = CTRL_W'($urandom); end
      if (g1) begin req_a1 = $urandom; req_b1 = $urandom; req_ctrl1 = CTRL_W'($urandom); end
    end
    rec_en = 0;
    chk("t3_ngrants", grant_port.size(), 4);
    for (int i = 0; i < 4 && i < grant_port.size(); i++) begin
      chk($sformatf("t3_order%0d", i), grant_port[i], exp_order[i]);
      if (i > 0) chk($sformatf("t3_gap%0d", i), grant_cyc[i] - grant_cyc[i-1], 3);
    end
    idle_inputs();
    tick(); tick(); tick();

    // 4. Backpressure on port 0 for five cycles.
    while (busy) begin rsp_ready0 = 1; rsp_ready1 = 1; tick(); end
    idle_inputs();
    req_valid0 = 1; req_a0 = 32'h1234_0000; req_b0 = 32'h0000_5678; req_ctrl0 = 3'd4;
    tick();
    req_valid0 = 0;
    tick();
    held_y = 32'h1234_5678;
    req_valid1 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_rspv0",  rsp_valid0, 1);
      chk("t4_y",      rsp_y, held_y);
      chk("t4_rdy0",   req_ready0, 0);
      chk("t4_rdy1",   req_ready1, 0);
      chk("t4_alu_a",  alu_a, 32'h1234_0000);
      chk("t4_alu_b",  alu_b, 32'h0000_5678);
    end
    req_valid1 = 0; rsp_ready0 = 1;
    tick();
    rsp_ready0 = 0;
    chk("t4_idle", busy, 0);
    chk("t4_rspv0_off", rsp_valid0, 0);

    // 6. Reset while the operation is executing.
    req_valid0 = 1; req_a0 = 32'd5; req_b0 = 32'd6;
    tick();
    req_valid0 = 0; rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_rsp0", rsp_valid0, 0);
      chk("t6_busy",    busy, 0);
    end
    req_valid0 = 1; req_valid1 = 1;
    #1;
    chk("t6_prio_rdy0", req_ready0, 1);
    chk("t6_prio_rdy1", req_ready1, 0);
    req_valid0 = 0; req_a1 = 32'd7; req_b1 = 32'd8;
    tick();
    req_valid1 = 0;
    tick();
    chk("t6_rspv1", rsp_valid1, 1);
    chk("t6_rspv0", rsp_valid0, 0);
    chk("t6_y",     rsp_y, 15);
    rsp_ready1 = 1;
    tick();
    idle_inputs();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 60) != 0);
      req_valid0 = $urandom_range(0, 1);
      req_valid1 = $urandom_range(0, 1);
      rsp_ready0 = ($urandom_range(0, 9) < 7);
      rsp_ready1 = ($urandom_range(0, 9) < 7);
      req_a0 = $urandom; req_b0 = $urandom; req_ctrl0 = CTRL_W'($urandom);
      req_a1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      req_b1 = $urandom; req_ctrl1 = CTRL_W'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the single 32-bit `alu` instance between two requesters.
- Each requester issues one operation (a, b, ctrl) through a valid/ready handshake.
- The arbiter registers the operands onto the ALU for one cycle, captures `y`/`cout`, and returns them on that requester's response port.
- It sits between the datapath front-ends and `alu`, which is the only ALU in the design.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match `alu`.
- `CTRL_W`, 3, ALU control width; must match `alu`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid0` / `req_valid1`  in  1  requester 0/1 has an operation.
- `req_ready0` / `req_ready1`  out  1  arbiter accepts that requester's operation this cycle.
- `req_a0` / `req_a1`  in  WIDTH  operand a.
- `req_b0` / `req_b1`  in  WIDTH  operand b.
- `req_ctrl0` / `req_ctrl1`  in  CTRL_W  ALU opcode, passed through unmodified.
- `rsp_valid0` / `rsp_valid1`  out  1  result available for requester 0/1.
- `rsp_ready0` / `rsp_ready1`  in  1  requester consumes the result.
- `rsp_y`  out  WIDTH  captured ALU result, shared by both response ports.
- `rsp_cout`  out  1  captured ALU carry-out.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to `alu.a` / `alu.b`.
- `alu_ctrl`  out  CTRL_W  registered opcode to `alu.ctrl`.
- `alu_y`  in  WIDTH  from `alu.y`.
- `alu_cout`  in  1  from `alu.cout`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Only one operation is in flight at any time.
- Round-robin pointer `prio` (1 bit) marks the favoured port; reset value is port 0.
- **IDLE** grant logic (combinational):
  - `req_ready0 = req_valid0 && (!req_valid1 || prio==0)`.
  - `req_ready1 = req_valid1 && (!req_valid0 || prio==1)`.
  - At most one ready is high.
- **IDLE -> EXEC** on accept (valid && ready):
  - Latch the granted port's a/b/ctrl into `alu_a`/`alu_b`/`alu_ctrl`.
  - Latch the owner id.
  - Set `prio` to the other port.
- **EXEC**: the ALU evaluates combinationally from the registered operands. At end of cycle, capture `alu_y`/`alu_cout` into `rsp_y`/`rsp_cout`; go to RESP.
- **RESP**:
  - Only the owner's `rsp_valid` is high.
  - On the owner's `rsp_ready`, go to IDLE.
  - The other port's `rsp_ready` is ignored.
- Readiness per state:
  - Both `req_ready` are low in EXEC and RESP.
  - A new request is accepted only in IDLE. There is no RESP->EXEC bypass.
- Hold rules:
  - `alu_a`/`alu_b`/`alu_ctrl` hold their values through EXEC and RESP, and remain at the last operation while IDLE.
  - `rsp_y`/`rsp_cout` are stable while `rsp_valid` is high and hold afterwards.
- The arbiter never decodes `ctrl`. Width rules are owned by `alu`; the arbiter performs no arithmetic.

## Timing
- Reset (`rst_n` low at a rising edge):
  - State goes to IDLE and `prio` to 0.
  - `alu_a`, `alu_b`, `alu_ctrl`, `rsp_y`, `rsp_cout`, `rsp_valid0/1` and `busy` all go to 0.
  - `req_ready0/1` are forced to 0 while `rst_n` is low.
- Latency: accept at edge N, `alu_*` valid in cycle N+1, `rsp_valid` high in cycle N+2.
- Minimum issue interval is 3 cycles per operation (accept, EXEC, RESP with same-cycle `rsp_ready`).
- Simultaneous valids: the `prio` port wins; the loser's `req_valid` must stay asserted and it wins the next arbitration.
- Single requester: it is granted regardless of `prio`, and `prio` still flips to the other port.
- Reset mid-EXEC or mid-RESP: the in-flight operation is dropped, no response is ever issued for it, and `prio` returns to 0.
- Response backpressure is unlimited; the arbiter holds RESP indefinitely.

## Test plan
Bench ALU model: `y = a + b`, `cout` = carry, for every `ctrl` value.
1. **Reset:** hold `rst_n` low 2 cycles with both `req_valid` high -> `req_ready0/1`=0, `rsp_valid0/1`=0, `alu_a`=`alu_b`=0, `alu_ctrl`=0, `busy`=0.
2. **Single op, port 0:** a=16, b=3, ctrl=3'b010 -> `req_ready0`=1 at cycle N; cycle N+1 `alu_a`=16, `alu_b`=3, `alu_ctrl`=3'b010; cycle N+2 `rsp_valid0`=1, `rsp_y`=19, `rsp_cout`=0, `rsp_valid1`=0.
3. **Contention:** both ports hold valid continuously from reset with `rsp_ready` tied high -> grant order 0,1,0,1; each response goes only to its owner, every 3 cycles.
4. **Backpressure:** `rsp_ready0` low for 5 cycles in RESP -> `rsp_valid0` held, `rsp_y` unchanged, both `req_ready`=0, `alu_*` unchanged; release -> IDLE next cycle.
5. **Carry:** a=32'hFFFF_FFFF, b=1 on port 1 -> `rsp_valid1`=1, `rsp_y`=0, `rsp_cout`=1.
6. **Reset in EXEC:** pulse `rst_n` low during EXEC -> no `rsp_valid` for the dropped op; next request (port 1 alone) completes normally and returns to port 1.
